// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with init sweep, write bypass and busy scoreboard
//
// Purpose
//   After reset, a control FSM sweeps every register once (one per cycle) to load
//   its initial value. After the sweep the block enters RUN and raises o_Ready.
//   In RUN it provides:
//     - two write ports, with B taking priority on an address collision;
//     - NUM_RD combinational read ports that bypass same-cycle writes;
//     - a per-register busy scoreboard, set by issue and cleared by a committed write.
//   Register 0 is hard zero and is never busy.
//
// Ports
//   i_Clk           clock, all state updates on the rising edge
//   reset           asynchronous active-low reset
//   i_RD_Addr       packed read addresses, port k at [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   o_RD_Data       packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_RD_Busy       per read port, addressed register has a pending write
//   i_WrA_*         write port A (enable / address / data)
//   i_WrB_*         write port B (enable / address / data), wins over A on the same address
//   i_Issue_*       marks the destination register as pending
//   o_Ready         initialisation complete, block accepts traffic
//   outputReg       stored contents of register DEBUG_REG (no bypass)

module regfile_mp #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter int                    NUM_RD         = 2,
    parameter logic [DATA_WIDTH-1:0] SP_INIT        = 32'h7fffeffc,
    parameter logic [DATA_WIDTH-1:0] GP_INIT        = 32'h10008000,
    parameter int                    DEBUG_REG      = 2
) (
    input  logic                             i_Clk,
    input  logic                             reset,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] i_RD_Addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     o_RD_Data,
    output logic [NUM_RD-1:0]                o_RD_Busy,
    input  logic                             i_WrA_Enable,
    input  logic [REG_ADDR_WIDTH-1:0]        i_WrA_Addr,
    input  logic [DATA_WIDTH-1:0]            i_WrA_Data,
    input  logic                             i_WrB_Enable,
    input  logic [REG_ADDR_WIDTH-1:0]        i_WrB_Addr,
    input  logic [DATA_WIDTH-1:0]            i_WrB_Data,
    input  logic                             i_Issue_Enable,
    input  logic [REG_ADDR_WIDTH-1:0]        i_Issue_Addr,
    output logic                             o_Ready,
    output logic [DATA_WIDTH-1:0]            outputReg
);

    localparam int                        DEPTH   = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] DBG_IDX = REG_ADDR_WIDTH'(DEBUG_REG);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [DATA_WIDTH-1:0]       regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]       regs_d [DEPTH];

    logic                        run;
    logic                        wr_a_commit;
    logic                        wr_b_commit;
    logic                        issue_commit;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr [NUM_RD];

    function automatic logic [DATA_WIDTH-1:0] init_value(input logic [REG_ADDR_WIDTH-1:0] a);
        if (int'(a) == 29) begin
            return SP_INIT;
        end else if (int'(a) == 28) begin
            return GP_INIT;
        end else begin
            return '0;
        end
    endfunction

    // Writes, issues and reads are only honoured once the sweep has finished;
    // address 0 never commits so register 0 stays zero and never goes busy.
    assign run          = (state_q == ST_RUN);
    assign wr_a_commit  = run && i_WrA_Enable   && (i_WrA_Addr   != '0);
    assign wr_b_commit  = run && i_WrB_Enable   && (i_WrB_Addr   != '0);
    assign issue_commit = run && i_Issue_Enable && (i_Issue_Addr != '0);

    // Control FSM: INIT sweeps the counter across every address, then RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Register array next state. B is applied after A so it wins a collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (state_q == ST_INIT) begin
                if (init_cnt_q == REG_ADDR_WIDTH'(i)) begin
                    regs_d[i] = init_value(REG_ADDR_WIDTH'(i));
                end
            end else begin
                if (wr_a_commit && (i_WrA_Addr == REG_ADDR_WIDTH'(i))) begin
                    regs_d[i] = i_WrA_Data;
                end
                if (wr_b_commit && (i_WrB_Addr == REG_ADDR_WIDTH'(i))) begin
                    regs_d[i] = i_WrB_Data;
                end
            end
        end
    end

    // Storage carries no reset: contents are rebuilt by the init sweep.
    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Scoreboard: writes clear first, then an issue sets, so a new producer
    // issued alongside a write to the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_a_commit) begin
            busy_d[i_WrA_Addr] = 1'b0;
        end
        if (wr_b_commit) begin
            busy_d[i_WrB_Addr] = 1'b0;
        end
        if (issue_commit) begin
            busy_d[i_Issue_Addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Read ports: combinational, bypassing writes committing this cycle so a
    // reader never sees stale data or a busy flag the write is about to clear.
    always_comb begin
        o_RD_Data = '0;
        o_RD_Busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = i_RD_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            if (run && (rd_addr[k] != '0)) begin
                if (wr_b_commit && (i_WrB_Addr == rd_addr[k])) begin
                    o_RD_Data[k*DATA_WIDTH +: DATA_WIDTH] = i_WrB_Data;
                end else if (wr_a_commit && (i_WrA_Addr == rd_addr[k])) begin
                    o_RD_Data[k*DATA_WIDTH +: DATA_WIDTH] = i_WrA_Data;
                end else begin
                    o_RD_Data[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[k]];
                end
                o_RD_Busy[k] = busy_q[rd_addr[k]]
                             && !(wr_b_commit && (i_WrB_Addr == rd_addr[k]))
                             && !(wr_a_commit && (i_WrA_Addr == rd_addr[k]));
            end
        end
    end

    assign o_Ready   = run;
    assign outputReg = regs_q[DBG_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp against an array model

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic           i_Clk = 1'b0;
    logic           reset = 1'b0;
    logic [NR*AW-1:0] i_RD_Addr = '0;
    logic [NR*DW-1:0] o_RD_Data;
    logic [NR-1:0]  o_RD_Busy;
    logic           i_WrA_Enable = 1'b0;
    logic [AW-1:0]  i_WrA_Addr = '0;
    logic [DW-1:0]  i_WrA_Data = '0;
    logic           i_WrB_Enable = 1'b0;
    logic [AW-1:0]  i_WrB_Addr = '0;
    logic [DW-1:0]  i_WrB_Data = '0;
    logic           i_Issue_Enable = 1'b0;
    logic [AW-1:0]  i_Issue_Addr = '0;
    logic           o_Ready;
    logic [DW-1:0]  outputReg;

    int errors = 0;
    int checks = 0;

    regfile_mp dut (
        .i_Clk          (i_Clk),
        .reset          (reset),
        .i_RD_Addr      (i_RD_Addr),
        .o_RD_Data      (o_RD_Data),
        .o_RD_Busy      (o_RD_Busy),
        .i_WrA_Enable   (i_WrA_Enable),
        .i_WrA_Addr     (i_WrA_Addr),
        .i_WrA_Data     (i_WrA_Data),
        .i_WrB_Enable   (i_WrB_Enable),
        .i_WrB_Addr     (i_WrB_Addr),
        .i_WrB_Data     (i_WrB_Data),
        .i_Issue_Enable (i_Issue_Enable),
        .i_Issue_Addr   (i_Issue_Addr),
        .o_Ready        (o_Ready),
        .outputReg      (outputReg)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs  [DEPTH];
    bit            m_known [DEPTH];
    bit            m_busy  [DEPTH];
    bit            m_ready = 0;
    int            m_swept = 0;

    function automatic logic [DW-1:0] sweep_value(input int a);
        if (a == 29) return 32'h7fffeffc;
        if (a == 28) return 32'h10008000;
        return 32'h0;
    endfunction

    always @(posedge i_Clk or negedge reset) begin
        if (!reset) begin
            m_ready = 0;
            m_swept = 0;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
        end else if (!m_ready) begin
            m_regs[m_swept]  = sweep_value(m_swept);
            m_known[m_swept] = 1;
            m_swept++;
            if (m_swept == DEPTH) m_ready = 1;
        end else begin
            if (i_WrA_Enable && i_WrA_Addr != 0) begin
                m_regs[i_WrA_Addr] = i_WrA_Data;
                m_busy[i_WrA_Addr] = 0;
            end
            if (i_WrB_Enable && i_WrB_Addr != 0) begin
                m_regs[i_WrB_Addr] = i_WrB_Data;
                m_busy[i_WrB_Addr] = 0;
            end
            if (i_Issue_Enable && i_Issue_Addr != 0) m_busy[i_Issue_Addr] = 1;
        end
    end

    function automatic logic [DW:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        bit            b;
        bit            hit_a, hit_b;
        d = '0;
        b = 0;
        if (m_ready && a != 0) begin
            hit_b = i_WrB_Enable && (i_WrB_Addr == a);
            hit_a = i_WrA_Enable && (i_WrA_Addr == a);
            if (hit_b)      d = i_WrB_Data;
            else if (hit_a) d = i_WrA_Data;
            else            d = m_regs[a];
            b = m_busy[a] && !hit_a && !hit_b;
        end
        return {b, d};
    endfunction

    // Compare every cycle on the falling edge, away from the update edge.
    always @(negedge i_Clk) begin
        logic [DW:0] e;
        chk("model_ready", {31'b0, o_Ready}, {31'b0, m_ready});
        for (int k = 0; k < NR; k++) begin
            e = model_read(i_RD_Addr[k*AW +: AW]);
            chk($sformatf("model_rd_data%0d", k), o_RD_Data[k*DW +: DW], e[DW-1:0]);
            chk($sformatf("model_rd_busy%0d", k), {31'b0, o_RD_Busy[k]}, {31'b0, e[DW]});
        end
        if (m_known[2]) chk("model_outputreg", outputReg, m_regs[2]);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle();
        i_WrA_Enable = 0; i_WrB_Enable = 0; i_Issue_Enable = 0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        i_RD_Addr = {a1, a0};
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!o_Ready && n < 40) begin
            tick();
            n++;
        end
        chk(name, n, 32);
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_ready", {31'b0, o_Ready}, 32'h0);
        set_rd(5'd29, 5'd28);
        #1;
        chk("reset_rd_data", o_RD_Data[31:0], 32'h0);
        reset = 1'b1;
        // writes during the sweep must be ignored
        i_WrA_Enable = 1; i_WrA_Addr = 5'd5; i_WrA_Data = 32'h77;
        wait_ready("ready_latency");
        idle();
        #1;
        chk("r29_init", o_RD_Data[31:0],  32'h7fffeffc);
        chk("r28_init", o_RD_Data[63:32], 32'h10008000);
        set_rd(5'd5, 5'd0);
        #1;
        chk("r5_init_write_ignored", o_RD_Data[31:0], 32'h0);

        // A/B collision on r5
        i_WrA_Enable = 1; i_WrA_Addr = 5'd5; i_WrA_Data = 32'h11;
        i_WrB_Enable = 1; i_WrB_Addr = 5'd5; i_WrB_Data = 32'h22;
        #1;
        chk("collide_bypass", o_RD_Data[31:0], 32'h22);
        tick(); idle(); #1;
        chk("collide_stored", o_RD_Data[31:0], 32'h22);

        // issue r7 then write it
        i_Issue_Enable = 1; i_Issue_Addr = 5'd7;
        tick(); idle();
        set_rd(5'd7, 5'd7);
        #1;
        chk("r7_busy", {31'b0, o_RD_Busy[0]}, 32'h1);
        i_WrA_Enable = 1; i_WrA_Addr = 5'd7; i_WrA_Data = 32'hABCD;
        #1;
        chk("r7_wr_busy", {31'b0, o_RD_Busy[0]}, 32'h0);
        chk("r7_wr_data", o_RD_Data[31:0], 32'hABCD);
        tick(); idle(); #1;
        chk("r7_after_busy", {31'b0, o_RD_Busy[0]}, 32'h0);

        // issue + B write same register: stays busy
        i_Issue_Enable = 1; i_Issue_Addr = 5'd9;
        i_WrB_Enable = 1; i_WrB_Addr = 5'd9; i_WrB_Data = 32'h99;
        tick(); idle();
        set_rd(5'd9, 5'd9);
        #1;
        chk("r9_busy_kept", {31'b0, o_RD_Busy[0]}, 32'h1);
        chk("r9_data", o_RD_Data[31:0], 32'h99);
        chk("same_addr_ports", o_RD_Data[63:32], o_RD_Data[31:0]);
        chk("same_addr_busy", {31'b0, o_RD_Busy[1]}, 32'h1);

        // register 0
        i_WrA_Enable = 1; i_WrA_Addr = 5'd0; i_WrA_Data = 32'h5;
        i_Issue_Enable = 1; i_Issue_Addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        chk("r0_bypass", o_RD_Data[31:0], 32'h0);
        tick(); idle(); #1;
        chk("r0_data", o_RD_Data[31:0], 32'h0);
        chk("r0_busy", {31'b0, o_RD_Busy[0]}, 32'h0);

        // distinct A/B addresses both commit
        i_WrA_Enable = 1; i_WrA_Addr = 5'd10; i_WrA_Data = 32'hA;
        i_WrB_Enable = 1; i_WrB_Addr = 5'd11; i_WrB_Data = 32'hB;
        tick(); idle();
        set_rd(5'd10, 5'd11);
        #1;
        chk("r10_stored", o_RD_Data[31:0],  32'hA);
        chk("r11_stored", o_RD_Data[63:32], 32'hB);

        // debug register mirror
        i_WrA_Enable = 1; i_WrA_Addr = 5'd2; i_WrA_Data = 32'h5;
        #1;
        chk("outreg_same_cycle", outputReg, 32'h0);
        tick(); idle(); #1;
        chk("outreg_next", outputReg, 32'h5);

        // reset mid-RUN with r3 busy
        i_Issue_Enable = 1; i_Issue_Addr = 5'd3;
        tick(); idle();
        set_rd(5'd3, 5'd3);
        #1;
        chk("r3_busy_pre", {31'b0, o_RD_Busy[0]}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ready_async", {31'b0, o_Ready}, 32'h0);
        chk("rst_busy_async", {30'b0, o_RD_Busy}, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        wait_ready("ready_latency_rerun");
        #1;
        chk("r3_busy_post", {31'b0, o_RD_Busy[0]}, 32'h0);
        chk("outreg_reinit", outputReg, 32'h0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register address width; depth = 2**REG_ADDR_WIDTH.
REQ-003 Parameter NUM_RD, default 2, number of read ports, legal range 1..4.
REQ-004 Parameters SP_INIT = 32'h7fffeffc (reg 29), GP_INIT = 32'h10008000 (reg 28), DEBUG_REG = 2, the register mirrored on outputReg.
REQ-005 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 i_RD_Addr  input  NUM_RD*REG_ADDR_WIDTH  packed read addresses, port k at slice k.
REQ-008 o_RD_Data  output  NUM_RD*DATA_WIDTH  packed read data, port k at slice k.
REQ-009 o_RD_Busy  output  NUM_RD  per read port: addressed register has a pending write.
REQ-010 i_WrA_Enable / i_WrA_Addr / i_WrA_Data  input  1 / REG_ADDR_WIDTH / DATA_WIDTH  write port A.
REQ-011 i_WrB_Enable / i_WrB_Addr / i_WrB_Data  input  1 / REG_ADDR_WIDTH / DATA_WIDTH  write port B (priority port).
REQ-012 i_Issue_Enable / i_Issue_Addr  input  1 / REG_ADDR_WIDTH  marks destination register as pending.
REQ-013 o_Ready  output  1  high when initialisation complete and block accepts traffic.
REQ-014 outputReg  output  DATA_WIDTH  stored contents of register DEBUG_REG.

Function
REQ-015 Control FSM SHALL have two states, INIT and RUN; reset forces INIT with init counter = 0.
REQ-016 In INIT the block SHALL write one register per cycle at address = counter: SP_INIT at 29, GP_INIT at 28, 0 elsewhere; counter increments by 1.
REQ-017 After the write to address 2**REG_ADDR_WIDTH-1 the FSM SHALL enter RUN; o_Ready rises the cycle after that write (exactly 2**REG_ADDR_WIDTH cycles after reset release).
REQ-018 In INIT, write and issue inputs SHALL be ignored, o_RD_Data SHALL read 0 and o_RD_Busy SHALL read 0.
REQ-019 In RUN, an enabled write to a non-zero address SHALL update the register at the rising edge; writes to address 0 SHALL be discarded.
REQ-020 Simultaneous A and B writes to different addresses SHALL both commit; to the same address, B's data SHALL be stored.
REQ-021 Reads SHALL be combinational (zero latency); address 0 SHALL always return 0.
REQ-022 Reads SHALL bypass same-cycle writes: if B writes the read address, return i_WrB_Data; else if A writes it, return i_WrA_Data; else stored value.
REQ-023 Busy scoreboard: one bit per register; i_Issue_Enable sets bit i_Issue_Addr at the edge; any committed write clears its address's bit.
REQ-024 Issue and write to the same address in the same cycle SHALL leave the bit set (new producer wins).
REQ-025 Register 0 SHALL never be busy; issue to address 0 is ignored.
REQ-026 o_RD_Busy[k] SHALL equal busy[addr_k] AND NOT (same-cycle enabled write to addr_k), consistent with REQ-022.
REQ-027 outputReg SHALL show stored contents only (no bypass), updating the cycle after a write to DEBUG_REG.
REQ-028 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-029 Reset assertion SHALL immediately (asynchronously) force INIT, counter 0, o_Ready 0, all busy bits 0, regardless of state.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the full initialisation sweep after release; prior register contents are not guaranteed until o_Ready.
REQ-031 During and after reset until o_Ready, o_RD_Data, o_RD_Busy SHALL be 0; outputReg SHALL be 0 once address DEBUG_REG has been initialised.

Verification
REQ-032 Release reset, default params -> o_Ready rises exactly 32 cycles later; reads of r29 = 32'h7fffeffc, r28 = 32'h10008000, r5 = 0.
REQ-033 RUN: A writes r5=32'h11, B writes r5=32'h22 same cycle, port 0 reads r5 -> same-cycle data 32'h22, next cycle stored 32'h22.
REQ-034 RUN: issue r7, next cycle read r7 -> busy 1; A writes r7=32'hABCD -> same cycle busy 0, data 32'hABCD; following cycle busy 0.
REQ-035 RUN: issue r9 and B write r9 same cycle -> busy bit remains 1 afterwards; write to r0 and issue r0 -> read r0 = 0, busy 0.
REQ-036 Write r2=32'h5 -> outputReg 0 same cycle, 32'h5 next; assert reset mid-RUN with r3 busy -> o_Ready 0, busy 0 immediately, o_Ready returns 32 cycles after release.
